// File: rtl/serial_mod_checker.sv
// serial_mod_checker
// Bit-serial divisibility checker. Accepts a framed serial bit stream,
// MSB-first or LSB-first (chosen per frame), and keeps the running residue
// of the received value modulo MODULUS. The divisible flag is updated after
// every accepted bit, and done pulses for one cycle at the end of each frame.
//
// Handshake: there is no back-pressure. A beat is any cycle with
// in_valid = 1. In_first and in_last qualify that beat and are ignored
// while in_valid = 0. A beat is accepted when it starts a frame
// (in_first = 1, legal in any state) or when the checker is mid-frame (ACCUM).
// All other beats are dropped without side effects.
module serial_mod_checker #(
  parameter int  MODULUS = 3,
  parameter int  COUNT_W = 8,
  localparam int RW      = ($clog2(MODULUS) < 1) ? 1 : $clog2(MODULUS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lsb_first,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_last,
  input  logic               in,
  output logic [RW-1:0]      residue,
  output logic               out,
  output logic [COUNT_W-1:0] bit_count,
  output logic               busy,
  output logic               done,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // MODULUS widened to the intermediate width so that compares are unsigned
  // and equal-width.
  localparam logic [RW:0] MOD_V = (RW+1)'(MODULUS);

  state_t        state;
  logic [RW-1:0] w;       // 2^k mod MODULUS for the next LSB-first bit
  logic          order;   // latched bit order of the current frame

  // Operands for this beat. A frame-start beat starts from a clean slate:
  // residue 0, weight 1 and the freshly sampled bit order.
  logic [RW-1:0] base_r;
  logic [RW-1:0] w_eff;
  logic          order_eff;
  logic [RW:0]   msb_sum;
  logic [RW:0]   lsb_sum;
  logic [RW:0]   r_sum;
  logic [RW:0]   w_dbl;
  logic [RW-1:0] r_next;
  logic [RW-1:0] w_next;
  logic          accept;

  // Residue/weight update: one add followed by one conditional subtract.
  // Both operands are below MODULUS, so every sum is below 2*MODULUS and a
  // single subtract always brings it back into range.
  always_comb begin
    base_r    = in_first ? '0 : residue;
    w_eff     = in_first ? RW'(1) : w;
    order_eff = in_first ? lsb_first : order;

    // MSB-first: r' = 2r + in
    msb_sum   = {base_r, in};
    // LSB-first: r' = r + in * w
    lsb_sum   = {1'b0, base_r} + (in ? {1'b0, w_eff} : '0);
    r_sum     = order_eff ? lsb_sum : msb_sum;
    r_next    = (r_sum >= MOD_V) ? RW'(r_sum - MOD_V) : r_sum[RW-1:0];

    // Next weight: w' = 2w mod MODULUS
    w_dbl     = {w_eff, 1'b0};
    w_next    = (w_dbl >= MOD_V) ? RW'(w_dbl - MOD_V) : w_dbl[RW-1:0];

    accept    = in_valid && (in_first || (state == ACCUM));
  end

  // Frame FSM and all registered outputs. Reset overrides every input,
  // including a done pulse that would otherwise be issued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      residue   <= '0;
      out       <= 1'b1;
      bit_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w         <= RW'(1);
      order     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        residue <= r_next;
        out     <= (r_next == '0);
        // The weight only advances in LSB-first frames; in MSB-first
        // frames it is parked at 1 and never consulted.
        w       <= order_eff ? w_next : RW'(1);
        if (in_first) begin
          order     <= lsb_first;
          bit_count <= COUNT_W'(1);
        end else if (bit_count != '1) begin
          bit_count <= bit_count + 1'b1;
        end
        if (in_last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= ACCUM;
          busy  <= 1'b1;
        end
      end
    end
  end

  // Debug view of the FSM for checkers.
  assign fsm_state = state;

endmodule

// File: doc/serial_mod_checker.md
# serial_mod_checker

Parametrised bit-serial divisibility checker. It is the successor to the fixed divide-by-3 serial FSM. It accepts a framed serial bit stream, MSB-first or LSB-first selectable per frame, and tracks the running residue modulo a compile-time MODULUS. It flags divisibility after every accepted bit and pulses `done` at end of frame. It sits behind a serial input front end and feeds a result register or LED display.

## Interface
Parameters:
- MODULUS, 3: divisor; legal range 2..255.
- COUNT_W, 8: width of the accepted-bit counter.
- RW (localparam), clog2(MODULUS), minimum 1: residue width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- lsb_first  in  1  frame bit order (0 = MSB-first, 1 = LSB-first); sampled only on a frame-start beat.
- in_valid  in  1  current bit is valid.
- in_first  in  1  with in_valid: bit is the first bit of a new frame.
- in_last  in  1  with in_valid: bit is the last bit of the frame.
- in  in  1  serial data bit.
- residue  out  RW  value received so far mod MODULUS.
- out  out  1  divisible flag; high when residue == 0.
- bit_count  out  COUNT_W  bits accepted in the current or last frame; saturating.
- busy  out  1  high in ACCUM state.
- done  out  1  one-cycle pulse marking frame completion.

## Operation
- States: IDLE, ACCUM, DONE. Reset state is IDLE.
- Reset values: residue = 0, out = 1, bit_count = 0, busy = 0, done = 0. Internal weight w = 1 and order = 0.
- A beat is a cycle with in_valid = 1. Cycles with in_valid = 0 hold all state; `done` still clears.
- Frame-start beat (in_first = 1) is legal in any state:
  - latches order = lsb_first, clears bit_count, and sets w = 1;
  - computes residue from an initial residue of 0.
- Frame start while in ACCUM abandons the current frame and restarts with no `done` pulse.
- In IDLE or DONE, beats with in_first = 0 are ignored.
- MSB-first update: r' = 2r + in. If r' >= MODULUS, subtract MODULUS once. Intermediate width is RW+1.
- LSB-first update:
  - r' = r + (in ? w : 0), with one conditional subtract;
  - w' = 2w, with one conditional subtract;
  - w is not used in MSB-first mode.
- bit_count increments on each accepted beat and saturates at 2^COUNT_W - 1. Residue stays correct after saturation.
- Transitions:
  - Frame-start beat without in_last: go to ACCUM.
  - Beat with in_last = 1 (including a frame-start beat): go to DONE and pulse `done`.
- DONE holds residue, out, and bit_count until the next frame-start beat.

## Timing
- Latency is 1 cycle. residue, out, bit_count, and busy are registered and reflect all beats accepted up to the previous rising edge.
- `done` is high for exactly the one cycle after the edge that accepted the last beat. In that cycle residue and out already show the final result.
- Back-to-back frames are supported. A frame-start beat in the cycle `done` is high is accepted.
  - `done` then drops and busy rises in the next cycle.
  - The registered result of the old frame is overwritten at that edge.
- Reset has priority over every input. Reset low on any edge forces reset values on the next cycle, including mid-frame and in the `done` cycle; a pending `done` is cancelled.
- Throughput is one bit per cycle; the combinational path is one add plus one compare/subtract.

## Test plan
- MODULUS=3, MSB-first beats 1,1,0 (value 6), last on 3rd beat. Per cycle: residue 1,0,0 and out 0,1,1. `done` pulses once with bit_count = 3 and residue = 0.
- MODULUS=3, MSB-first 1,0,0 (value 4): residue 1,2,1; final out = 0; `done` = 1 for one cycle only.
- MODULUS=3, LSB-first 1,1,1,0,1 (value 23): residue 1,0,1,1,2; final out = 0. MODULUS=5, MSB-first 1,1,1,0,1 (value 29): residue 1,3,2,4,4.
- Reset low mid-frame after 2 beats: next cycle gives residue 0, out 1, bit_count 0, busy 0, and no `done`. Following beats with in_first = 0 are ignored.
- Restart and gaps, MODULUS=3:
  - frame start mid-frame restarts the count at 1 with no `done` pulse;
  - in_valid = 0 gaps hold residue;
  - a single beat with in_first = in_last = 1 and in = 1 gives residue 1, out 0, and a `done` pulse.
- COUNT_W=2, MODULUS=7, MSB-first 1,0,1,1,0 (value 22): bit_count saturates at 3; final residue 1; `done` pulses.
